// File: rtl/mod_dec_invshifter.sv
// ---------------------------------------------------------------------------
// mod_dec_invshifter
// Decryption-path InvShiftRows stage of the AES256 core. The state arrives
// one row per beat (four bytes, inp[0] = column 0). Row r is rotated right
// by r byte positions, which undoes the encryption row shifter. Both sides
// use valid/ready handshakes and the output row is registered.
//
// Ports:
//   clk        clock
//   resetn     asynchronous active-low reset
//   flush      synchronous clear of the output register and row tracking
//   in_valid   input row valid
//   in_ready   stage can take a row this cycle (combinational)
//   in_first   input row is row 0 of a new state block
//   inp        input row bytes
//   out_valid  output row valid
//   out_ready  downstream accepts the output row
//   outp       inverse-shifted row
//   out_row    row index (0..3) of the row on outp
//   out_last   row on outp is row 3
//   sync_err   one-cycle pulse when in_first arrives mid-block
//   blk_cnt    completed-block counter, wraps
// ---------------------------------------------------------------------------
module mod_dec_invshifter #(
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_first,
    input  logic [N-1:0][7:0]    inp,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0][7:0]    outp,
    output logic [1:0]           out_row,
    output logic                 out_last,
    output logic                 sync_err,
    output logic [CNT_W-1:0]     blk_cnt
);

    // Rotate a row right by amt byte positions: res[i] = row[(i - amt) mod 4].
    // The 2-bit index arithmetic performs the modulo-4 wrap.
    function automatic logic [N-1:0][7:0] inv_shift_row(
        input logic [N-1:0][7:0] row,
        input logic [1:0]        amt
    );
        logic [N-1:0][7:0] res;
        logic [1:0]        src;
        res = '0;
        for (int i = 0; i < N; i++) begin
            src    = 2'(i) - amt;
            res[i] = row[src];
        end
        return res;
    endfunction

    logic [N-1:0][7:0]  outp_r;
    logic               out_valid_r;
    logic [1:0]         out_row_r;
    logic               out_last_r;
    logic               sync_err_r;
    logic [CNT_W-1:0]   blk_cnt_r;
    logic [1:0]         row_cnt_r;

    logic               in_ready_s;
    logic               accept_s;
    logic               done_s;
    logic [1:0]         eff_row_s;
    logic               misalign_s;
    logic [N-1:0][7:0]  rot_s;
    logic [1:0]         row_next_s;

    // Handshake decode, effective row selection and rotation of the offered row.
    always_comb begin
        in_ready_s = 1'b0;
        accept_s   = 1'b0;
        done_s     = 1'b0;
        eff_row_s  = 2'd0;
        misalign_s = 1'b0;
        rot_s      = '0;
        row_next_s = 2'd0;

        in_ready_s = !out_valid_r || out_ready;
        accept_s   = in_valid && in_ready_s;
        done_s     = out_valid_r && out_ready;
        // in_first forces row 0 so a misaligned block resynchronises at once.
        if (in_first) begin
            eff_row_s = 2'd0;
        end else begin
            eff_row_s = row_cnt_r;
        end
        misalign_s = in_first && (row_cnt_r != 2'd0);
        rot_s      = inv_shift_row(inp, eff_row_s);
        if (eff_row_s == 2'd3) begin
            row_next_s = 2'd0;
        end else begin
            row_next_s = eff_row_s + 2'd1;
        end
    end

    // Output row register, row tracking and misalignment pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            outp_r      <= '0;
            out_valid_r <= 1'b0;
            out_row_r   <= 2'd0;
            out_last_r  <= 1'b0;
            sync_err_r  <= 1'b0;
            row_cnt_r   <= 2'd0;
        end else if (flush) begin
            // Drop the held row and any row offered this cycle; outp keeps its value.
            out_valid_r <= 1'b0;
            row_cnt_r   <= 2'd0;
            sync_err_r  <= 1'b0;
        end else begin
            sync_err_r <= accept_s && misalign_s;
            if (accept_s) begin
                // A new row replaces the old one even when it completes this cycle.
                outp_r      <= rot_s;
                out_row_r   <= eff_row_s;
                out_last_r  <= (eff_row_s == 2'd3);
                out_valid_r <= 1'b1;
                row_cnt_r   <= row_next_s;
            end else if (done_s) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

    // Completed-block counter: counts delivered last rows, untouched by flush.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            blk_cnt_r <= {CNT_W{1'b0}};
        end else if (flush) begin
            blk_cnt_r <= blk_cnt_r;
        end else if (done_s && out_last_r) begin
            blk_cnt_r <= blk_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            blk_cnt_r <= blk_cnt_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign outp      = outp_r;
    assign out_row   = out_row_r;
    assign out_last  = out_last_r;
    assign sync_err  = sync_err_r;
    assign blk_cnt   = blk_cnt_r;

endmodule

// File: tb/tb_mod_dec_invshifter.sv
// ---------------------------------------------------------------------------
// tb_mod_dec_invshifter
// Self-checking bench for mod_dec_invshifter. A transaction-level reference
// model predicts each delivered row from the rotation rule with plain
// modulo arithmetic; scenario tasks compare delivered rows, counters and
// status against the model or against fixed expected values.
// ---------------------------------------------------------------------------
module tb_mod_dec_invshifter;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  row;
        logic        last;
    } beat_t;

    logic             clk;
    logic             resetn;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic             in_first;
    logic [3:0][7:0]  inp;
    logic             out_valid;
    logic             out_ready;
    logic [3:0][7:0]  outp;
    logic [1:0]       out_row;
    logic             out_last;
    logic             sync_err;
    logic [7:0]       blk_cnt;

    int    n_cmp;
    int    n_err;
    beat_t got_q[$];
    beat_t exp_q[$];
    beat_t pend;
    bit    pend_v;
    int    m_cnt;
    int    exp_blk;
    bit    sync_due;
    int    sync_bad;
    int    valid_bad;
    int    bubbles;

    mod_dec_invshifter #(.N(4), .CNT_W(8)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_first  (in_first),
        .inp       (inp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .outp      (outp),
        .out_row   (out_row),
        .out_last  (out_last),
        .sync_err  (sync_err),
        .blk_cnt   (blk_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected delivered row: byte i comes from input byte (i - r) mod 4.
    function automatic beat_t ref_beat(input logic [31:0] d, input int r);
        beat_t b;
        for (int i = 0; i < 4; i++) begin
            b.data[i*8 +: 8] = d[((i - r + 4) % 4)*8 +: 8];
        end
        b.row  = 2'(r);
        b.last = (r == 3);
        return b;
    endfunction

    // One clock: observe at the falling edge, update the model, return after the rising edge.
    task automatic tick(output bit acc);
        bit    done;
        beat_t g;
        int    r;
        @(negedge clk);
        if (resetn && (sync_err !== sync_due)) sync_bad++;
        if (resetn && (out_valid !== pend_v)) valid_bad++;
        acc  = resetn && in_valid && in_ready && !flush;
        done = resetn && out_valid && out_ready;
        if (done) begin
            g.data = outp;
            g.row  = out_row;
            g.last = out_last;
            got_q.push_back(g);
            exp_q.push_back(pend);
            if (pend.last && !flush) exp_blk = (exp_blk + 1) % 256;
        end
        sync_due = 1'b0;
        if (!resetn) begin
            pend_v = 1'b0;
        end else if (flush) begin
            pend_v = 1'b0;
            m_cnt  = 0;
        end else if (acc) begin
            r        = in_first ? 0 : m_cnt;
            sync_due = in_first && (m_cnt != 0);
            pend     = ref_beat(inp, r);
            pend_v   = 1'b1;
            m_cnt    = (r + 1) % 4;
        end else if (done) begin
            pend_v = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    // Offer one row and wait (bounded) until it is taken.
    task automatic send_row(input logic [31:0] d, input bit first);
        bit a;
        int n;
        inp      = d;
        in_first = first;
        in_valid = 1'b1;
        n        = 0;
        a        = 1'b0;
        while (!a && n < 50) begin
            tick(a);
            if (!a) bubbles++;
            n++;
        end
        if (!a) begin
            n_err++;
            $display("FAIL send_timeout: row %h not accepted within 50 cycles", d);
        end
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    task automatic drain();
        bit a;
        in_valid  = 1'b0;
        in_first  = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick(a);
    endtask

    task automatic clear_obs();
        got_q.delete();
        exp_q.delete();
        sync_bad  = 0;
        valid_bad = 0;
        bubbles   = 0;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if ({outp, out_valid, out_row, out_last, sync_err, blk_cnt} !== 45'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got outp=%h v=%b row=%0d last=%b se=%b blk=%0d required all zero",
                     outp, out_valid, out_row, out_last, sync_err, blk_cnt);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic test_rotation();
        logic [31:0] want [4];
        want[0] = 32'h33221100;
        want[1] = 32'h22110033;
        want[2] = 32'h11003322;
        want[3] = 32'h00332211;
        clear_obs();
        for (int k = 0; k < 4; k++) send_row(32'h33221100, k == 0);
        drain();
        n_cmp++;
        if (got_q.size() != 4) begin
            n_err++;
            $display("FAIL rot_count: got %0d beats required 4", got_q.size());
        end
        for (int k = 0; k < 4 && k < got_q.size(); k++) begin
            n_cmp++;
            if (got_q[k] !== {want[k], 2'(k), (k == 3)}) begin
                n_err++;
                $display("FAIL rot_beat%0d: got %h/row%0d/last%b required %h/row%0d/last%b",
                         k, got_q[k].data, got_q[k].row, got_q[k].last, want[k], k, k == 3);
            end
        end
        n_cmp++;
        if (blk_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL rot_blk_cnt: got %0d required 1", blk_cnt);
        end
    endtask

    task automatic test_round_trip();
        clear_obs();
        send_row($urandom, 1'b1);
        send_row(32'h00332211, 1'b0);
        drain();
        n_cmp++;
        if (got_q.size() != 2 || got_q[1] !== {32'h33221100, 2'd1, 1'b0}) begin
            n_err++;
            $display("FAIL round_trip: got %0d beats, last %h required 33221100 row 1",
                     got_q.size(), got_q.size() > 1 ? got_q[1].data : 32'h0);
        end
    endtask

    task automatic test_backpressure();
        bit          a;
        logic [31:0] held;
        logic [31:0] d [4];
        for (int k = 0; k < 4; k++) d[k] = $urandom;
        clear_obs();
        out_ready = 1'b1;
        send_row(d[0], 1'b1);
        out_ready = 1'b0;
        inp       = d[1];
        in_valid  = 1'b1;
        held      = outp;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++;
            if (in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_in_ready c%0d: got %b required 0", c, in_ready);
            end
            tick(a);
            n_cmp++;
            if (outp !== held || out_row !== 2'd0 || out_valid !== 1'b1) begin
                n_err++;
                $display("FAIL bp_hold c%0d: got %h row%0d v%b required %h row0 v1",
                         c, outp, out_row, out_valid, held);
            end
        end
        out_ready = 1'b1;
        send_row(d[1], 1'b0);
        send_row(d[2], 1'b0);
        send_row(d[3], 1'b0);
        drain();
        n_cmp++;
        if (got_q.size() != 4) begin
            n_err++;
            $display("FAIL bp_count: got %0d beats required 4", got_q.size());
        end
        for (int k = 0; k < got_q.size(); k++) begin
            n_cmp++;
            if (got_q[k] !== exp_q[k] || got_q[k].row !== 2'(k)) begin
                n_err++;
                $display("FAIL bp_beat%0d: got %h required %h", k, got_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_misalign();
        logic [31:0] d;
        clear_obs();
        send_row($urandom, 1'b1);
        send_row($urandom, 1'b0);
        d = $urandom;
        send_row(d, 1'b1);
        for (int k = 0; k < 3; k++) send_row($urandom, 1'b0);
        drain();
        n_cmp++;
        if (sync_bad != 0) begin
            n_err++;
            $display("FAIL mis_sync_err: %0d cycles wrong required 0", sync_bad);
        end
        n_cmp++;
        if (got_q.size() != 6 || got_q[2] !== {d, 2'd0, 1'b0}) begin
            n_err++;
            $display("FAIL mis_resync_row: got %0d beats, third %h required %h row 0",
                     got_q.size(), got_q.size() > 2 ? got_q[2] : 35'h0, d);
        end
        for (int k = 0; k < got_q.size(); k++) begin
            n_cmp++;
            if (got_q[k] !== exp_q[k]) begin
                n_err++;
                $display("FAIL mis_beat%0d: got %h required %h", k, got_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_flush();
        bit          a;
        logic [31:0] d;
        logic [7:0]  blk_before;
        clear_obs();
        blk_before = blk_cnt;
        send_row($urandom, 1'b1);
        send_row($urandom, 1'b0);
        flush    = 1'b1;
        in_valid = 1'b1;
        inp      = $urandom;
        tick(a);
        flush    = 1'b0;
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || blk_cnt !== blk_before) begin
            n_err++;
            $display("FAIL flush_clear: got v=%b blk=%0d required v=0 blk=%0d",
                     out_valid, blk_cnt, blk_before);
        end
        d = $urandom;
        send_row(d, 1'b0);
        drain();
        n_cmp++;
        if (got_q.size() == 0 || got_q[got_q.size()-1] !== {d, 2'd0, 1'b0}) begin
            n_err++;
            $display("FAIL flush_row0: got %h required %h row 0",
                     got_q.size() > 0 ? got_q[got_q.size()-1] : 35'h0, d);
        end
    endtask

    task automatic test_reset_midblock();
        logic [31:0] d;
        clear_obs();
        send_row($urandom, 1'b1);
        send_row($urandom, 1'b0);
        resetn = 1'b0;
        #1;
        n_cmp++;
        if ({outp, out_valid, out_row, out_last, sync_err, blk_cnt} !== 45'd0) begin
            n_err++;
            $display("FAIL midreset_outputs: got outp=%h v=%b row=%0d blk=%0d required all zero",
                     outp, out_valid, out_row, blk_cnt);
        end
        pend_v   = 1'b0;
        m_cnt    = 0;
        exp_blk  = 0;
        sync_due = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        d = $urandom;
        send_row(d, 1'b0);
        drain();
        n_cmp++;
        if (got_q.size() != 2 || got_q[1] !== {d, 2'd0, 1'b0}) begin
            n_err++;
            $display("FAIL midreset_row0: got %0d beats required 2 ending %h row 0", got_q.size(), d);
        end
    endtask

    task automatic test_wrap();
        clear_obs();
        for (int b = 0; b < 256; b++) begin
            if (b == 128) begin
                n_cmp++;
                if (blk_cnt !== 8'(exp_blk)) begin
                    n_err++;
                    $display("FAIL wrap_mid_blk: got %0d required %0d", blk_cnt, exp_blk);
                end
            end
            for (int r = 0; r < 4; r++) send_row($urandom, r == 0);
        end
        drain();
        n_cmp++;
        if (blk_cnt !== 8'd0 || bubbles != 0) begin
            n_err++;
            $display("FAIL wrap_blk: got blk=%0d bubbles=%0d required 0/0", blk_cnt, bubbles);
        end
        n_cmp++;
        if (got_q.size() != 1024) begin
            n_err++;
            $display("FAIL wrap_count: got %0d beats required 1024", got_q.size());
        end
        for (int k = 0; k < got_q.size(); k++) begin
            n_cmp++;
            if (got_q[k] !== exp_q[k] || got_q[k].row !== 2'(k % 4)) begin
                n_err++;
                $display("FAIL wrap_beat%0d: got %h required %h", k, got_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_random();
        bit a;
        clear_obs();
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_first  = ($urandom_range(0, 9) == 0);
            flush     = ($urandom_range(0, 39) == 0);
            inp       = $urandom;
            tick(a);
        end
        flush = 1'b0;
        drain();
        n_cmp++;
        if (valid_bad != 0 || sync_bad != 0) begin
            n_err++;
            $display("FAIL rnd_status: out_valid wrong %0d cycles, sync_err wrong %0d cycles required 0/0",
                     valid_bad, sync_bad);
        end
        n_cmp++;
        if (blk_cnt !== 8'(exp_blk)) begin
            n_err++;
            $display("FAIL rnd_blk_cnt: got %0d required %0d", blk_cnt, exp_blk);
        end
        for (int k = 0; k < got_q.size(); k++) begin
            n_cmp++;
            if (got_q[k] !== exp_q[k]) begin
                n_err++;
                $display("FAIL rnd_beat%0d: got %h required %h", k, got_q[k], exp_q[k]);
            end
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        pend      = '0;
        pend_v    = 1'b0;
        m_cnt     = 0;
        exp_blk   = 0;
        sync_due  = 1'b0;
        sync_bad  = 0;
        valid_bad = 0;
        bubbles   = 0;
        resetn    = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_first  = 1'b0;
        inp       = '0;
        out_ready = 1'b1;

        test_reset();
        test_rotation();
        test_round_trip();
        test_backpressure();
        test_misalign();
        test_flush();
        test_reset_midblock();
        test_wrap();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mod_dec_invshifter.md
Name: mod_dec_invshifter

Overview:
Decryption-path InvShiftRows stage for the AES256 core. It accepts the state one row per beat, four bytes per row, and rotates row r right by r byte positions. This is the exact inverse of the encryption row shifter. It sits between the InvSubBytes row register and the AddRoundKey/InvMixColumns stage, and uses valid/ready handshakes on both sides with a registered output.

Parameters:
N, 4, bytes per row (fixed at 4 for AES; other values unsupported)
CNT_W, 8, width of the completed-block counter

Ports:
clk  input  1  clock
resetn  input  1  reset, asynchronous, active-low
flush  input  1  synchronous clear of pipeline and row tracking
in_valid  input  1  input row valid
in_ready  output  1  block can accept a row this cycle
in_first  input  1  marks the input row as row 0 of a new state block
inp  input  [N-1:0][7:0]  input row bytes, inp[0] = column 0
out_valid  output  1  output row valid
out_ready  input  1  downstream accepts the output row
outp  output  [N-1:0][7:0]  inverse-shifted row
out_row  output  2  row index (0..3) of the row on outp
out_last  output  1  high when out_row == 3
sync_err  output  1  one-cycle pulse on in_first misalignment
blk_cnt  output  CNT_W  count of completed blocks, wraps

Behaviour:
- Reset (resetn low, asynchronous): outp=0, out_valid=0, out_row=0, out_last=0, sync_err=0, blk_cnt=0, row counter=0. Inputs are ignored while resetn is low. Reset mid-block discards the partial block; no output is produced for it.
- in_ready = !out_valid || out_ready (combinational). An input beat is accepted when in_valid && in_ready. An output beat completes when out_valid && out_ready.
- Latency: 1 cycle from acceptance to out_valid. Throughput is 1 row per cycle with out_ready held high.
- Effective row index eff_r:
  - 0 if in_first is high;
  - otherwise the internal row counter.
- Rotation rule: outp[i] = inp[(i - eff_r) mod 4], i.e. rotate right by eff_r.
  - eff_r=1: outp = {inp[3],inp[0],inp[1],inp[2]} for outp[0..3].
- On acceptance:
  - outp and out_row load eff_r; out_last = (eff_r==3); out_valid=1.
  - Row counter = (eff_r==3) ? 0 : eff_r+1, so it wraps 3 -> 0.
- When an output beat completes and no new input is accepted the same cycle, out_valid goes to 0. outp holds its last value.
- Output stall: while out_valid && !out_ready, outp, out_row and out_last are held stable and in_ready=0.
- Alignment: in_first accepted while the row counter != 0:
  - sync_err pulses high for exactly one cycle, the cycle after acceptance;
  - the row is processed as row 0 and the counter resyncs.
  - in_first with counter == 0 is legal and raises no error.
- blk_cnt increments by 1 (modulo 2^CNT_W) on each completed output beat with out_last=1.
- flush (synchronous, highest priority after reset): next cycle out_valid=0, row counter=0, sync_err=0.
  - Any input offered in the flush cycle is dropped.
  - blk_cnt is preserved.
- Simultaneous output completion and input acceptance in one cycle: the new row replaces the old one and out_valid stays 1.

Test Plan:
- Row rotation, with out_ready=1 and inp[0..3] = 00,11,22,33 sent four times, in_first on the first beat -> outp[0..3]:
  - beat 1: 00,11,22,33;
  - beat 2: 33,00,11,22;
  - beat 3: 22,33,00,11;
  - beat 4: 11,22,33,00.
  - out_row = 0,1,2,3; out_last only on the 4th beat; blk_cnt = 1.
- Round trip: encryption-shifter outputs for row 1 (11,22,33,00) fed in as row 1 -> outp = 00,11,22,33.
- Backpressure: hold out_ready=0 for 3 cycles after the first output -> outp stable, in_ready=0, no beat lost. After release, rows arrive in order with correct out_row.
- Misalignment: in_first asserted on the 3rd beat of a block (counter=2) -> sync_err high for one cycle, that row output unrotated with out_row=0, following rows are 1,2,3.
- Flush and reset: flush after 2 rows -> out_valid=0 next cycle and the next row is treated as row 0. resetn pulsed low mid-block -> all outputs 0 immediately and blk_cnt=0.
- Wrap: 256 back-to-back blocks with CNT_W=8 -> blk_cnt returns to 0. There is no bubble between blocks and the row counter wraps 3->0 each block.
